adcemu_tx: RTL and testbench
============================

// Module: adcemu_tx
// PURPOSE
//  Transmit-side ADC emulator: generates the 12-bit, 4-channel, two-lane bytewise stream (6-bit words per lane
//  per CLK, plus 6-bit frame word) that the ADC receiver chain consumes after deserialization.
//  Used in loopback/self-test builds in place of the real ADC.
//  Injects test patterns and programmable per-lane bit slips so the receiver's bitslip alignment, instability
//  counters and test-data checkers can be exercised without hardware.
// PARAMETERS
//  NCH        4          number of ADC channels
//  LANE_W     6          bits per lane per CLK (half of a 12-bit sample)
//  FRAME_PAT  6'b111000  frame word emitted each CLK, MSB = first bit on line
//  RAMP_STEP  1          ramp increment per sample
// PORTS
//  CLK        in   1   data clock (125 MHz domain), all logic rising-edge
//  RST_N      in   1   asynchronous active-low reset
//  EN         in   1   1 = emit samples; 0 = DOUT forced 0, frame keeps running
//  PAT_TYPE   in   4   pattern select, same numbering as receiver chk_type
//  USER_WORD  in   12  fixed word for PAT_TYPE=5
//  DIN        in   48  user samples for PAT_TYPE=0, channel i in DIN[12i+11:12i]
//  SLIP       in   27  per-lane slip amount, 3 bits/lane: lanes 0-7 data, lane 8 frame
//  SLIP_LD    in   1   pulse: load SLIP into lane slip registers
//  DOUT       out  48  lane words: lane 2i = ch i bits 5:0, lane 2i+1 = ch i bits 11:6
//  FR         out  6   frame lane word
//  SYNC       out  1   1-CLK pulse on the output cycle carrying ramp value 0
//  SMP_CNT    out  32  samples emitted while EN=1
// BEHAVIOUR
//  Reset: DOUT=0, FR=0, SYNC=0, SMP_CNT=0, ramp=0, alt phase=0, all slips=0, all previous-word registers=0.
//  Stage 1, sample gen (registered), per PAT_TYPE:
//   0 DIN passthrough; 1 12'h000; 2 12'hFFF; 3 alternating 12'hAAA/12'h555, starting 12'hAAA after reset;
//   4 ramp, all channels same value, +RAMP_STEP per CLK, wraps 4095->0; 5 USER_WORD; 6-15 -> 12'h000.
//   Ramp counter and alt phase advance only when EN=1, in every mode (free-running, pattern-independent).
//   EN=0: stage-1 sample forced 0, ramp/phase/SMP_CNT hold.
//  Stage 2, lane slip (registered): per lane, cur = stage-1 lane word, prev = that lane's previous cur;
//   out = ({prev,cur} >> k)[5:0], k = lane slip. k=0 -> cur; k=1 -> {prev[0],cur[5:1]}.
//   This delays the serial bit stream by k bits. Frame lane uses FRAME_PAT as cur every cycle.
//  SLIP_LD=1: slip registers load SLIP at that edge; the new k applies from the next output word.
//   Slip values 6,7 saturate to 5. A slip change may emit one mixed word; this is intended and not masked.
//  Latency: PAT_TYPE/DIN/EN sampled at edge n appear on DOUT after edge n+1 (2 CLK). SYNC is aligned with DOUT.
//  SMP_CNT increments at the stage-2 edge for each word with EN=1; it wraps at 2^32 without saturation.
//  PAT_TYPE change mid-run takes effect on the next sample; the ramp does not restart.
//  EN falling: the in-flight sample still exits, then DOUT=0. FR is always FRAME_PAT after reset, slipped per lane 8.
//  RST_N asserted mid-run clears everything immediately. First FR=FRAME_PAT appears 1 edge after RST_N release.
// STRUCTURE
//  Shared package: PAT_* codes (0-5), FRAME_PAT, LANE_W, NCH, SLIP_MAX=5.
//  One sub-module: adcemu_lane_slip (prev register, slip register with saturation, window select).
//  It is instantiated 9 times: 8 data lanes + frame. The top holds the pattern generator, SMP_CNT and SYNC.
// TESTING
//  Reset, EN=1, PAT=4, slips 0 -> ch0 {DOUT[11:6],DOUT[5:0]} = 0,1,2,...; SYNC at 0 and again 4096 CLK later.
//  PAT=3 -> each channel alternates 12'hAAA/12'h555; lane0 = 6'h2A then 6'h15. PAT=2 -> DOUT=48'hFFFF_FFFF_FFFF.
//  PAT=1 steady, SLIP lane8=2 via SLIP_LD -> FR goes 6'b111000 -> 6'b001110 steady; data lanes unchanged.
//  PAT=5, USER_WORD=12'hABC, lane0 slip=1 -> lane0 = {prev[0],cur[5:1]} = 6'b011110 steady; lane1 = 6'h2A.
//  SLIP=3'b111 on lane3 -> behaves as slip 5. EN low for 10 CLK -> DOUT=0, SMP_CNT holds, FR continues.
//  RST_N pulse mid-ramp at value 100 -> all outputs 0 at once; after release the ramp restarts at 0 with SYNC.

Source files
------------

// File: rtl/adcemu_tx_pkg.sv
// rtl/adcemu_tx_pkg.sv - shared constants, pattern codes and slip saturation for the ADC emulator
package adcemu_tx_pkg;

  localparam int NCH      = 4;
  localparam int LANE_W   = 6;
  localparam int SAMPLE_W = 2 * LANE_W;
  localparam int NLANE    = 2 * NCH;
  localparam int SLIP_W   = 3;

  localparam logic [LANE_W-1:0]   FRAME_PAT = 6'b111000;
  localparam logic [SLIP_W-1:0]   SLIP_MAX  = 3'd5;
  localparam logic [SAMPLE_W-1:0] RAMP_STEP = 12'd1;

  typedef enum logic [3:0] {
    PAT_DIN  = 4'd0,
    PAT_ZERO = 4'd1,
    PAT_ONES = 4'd2,
    PAT_ALT  = 4'd3,
    PAT_RAMP = 4'd4,
    PAT_USER = 4'd5
  } pat_e;

  function automatic logic [SLIP_W-1:0] sat_slip(input logic [SLIP_W-1:0] s);
    return (s > SLIP_MAX) ? SLIP_MAX : s;
  endfunction

endpackage

// File: rtl/adcemu_tx_if.sv
// rtl/adcemu_tx_if.sv - control inputs and lane outputs of the ADC emulator
interface adcemu_tx_if
  import adcemu_tx_pkg::*;
  ();

  logic                       en;
  logic [3:0]                 pat_type;
  logic [SAMPLE_W-1:0]        user_word;
  logic [NCH*SAMPLE_W-1:0]    din;
  logic [(NLANE+1)*SLIP_W-1:0] slip;
  logic                       slip_ld;
  logic [NLANE*LANE_W-1:0]    dout;
  logic [LANE_W-1:0]          fr;
  logic                       sync;
  logic [31:0]                smp_cnt;

  modport master (
    output en, pat_type, user_word, din, slip, slip_ld,
    input  dout, fr, sync, smp_cnt
  );

  modport slave (
    input  en, pat_type, user_word, din, slip, slip_ld,
    output dout, fr, sync, smp_cnt
  );

endinterface

// File: rtl/adcemu_lane_slip.sv
// rtl/adcemu_lane_slip.sv - one lane: delays the serial bit stream by k bits using the previous word
module adcemu_lane_slip
  import adcemu_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANE_W-1:0] cur,
  input  logic [SLIP_W-1:0] slip,
  input  logic              load,
  output logic [LANE_W-1:0] word
);

  logic [LANE_W-1:0]   prev;
  logic [SLIP_W-1:0]   k;
  logic [2*LANE_W-1:0] cat;

  assign cat = {prev, cur};

  // The output uses the slip held before this edge, so a new load takes effect one word later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      k    <= '0;
      word <= '0;
    end else begin
      prev <= cur;
      word <= cat[k +: LANE_W];
      if (load) begin
        k <= sat_slip(slip);
      end
    end
  end

endmodule

// File: rtl/adcemu_tx.sv
// rtl/adcemu_tx.sv - pattern generator plus per-lane slip stage producing the emulated ADC lane stream
module adcemu_tx
  import adcemu_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  adcemu_tx_if.slave  bus
);

  logic [SAMPLE_W-1:0]     ramp;
  logic                    alt;
  logic [SAMPLE_W-1:0]     gen_word;
  logic [NCH*SAMPLE_W-1:0] s1_next;
  logic [NCH*SAMPLE_W-1:0] s1_data;
  logic                    s1_valid;
  logic                    s1_sync;
  logic                    sync_q;
  logic [31:0]             cnt_q;
  logic [NLANE*LANE_W-1:0] dout_w;
  logic [LANE_W-1:0]       fr_w;

  always_comb begin
    gen_word = '0;
    case (bus.pat_type)
      PAT_ONES: gen_word = 12'hFFF;
      PAT_ALT:  gen_word = alt ? 12'h555 : 12'hAAA;
      PAT_RAMP: gen_word = ramp;
      PAT_USER: gen_word = bus.user_word;
      default:  gen_word = '0;
    endcase
    s1_next = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (!bus.en) begin
        s1_next[ch*SAMPLE_W +: SAMPLE_W] = '0;
      end else if (bus.pat_type == PAT_DIN) begin
        s1_next[ch*SAMPLE_W +: SAMPLE_W] = bus.din[ch*SAMPLE_W +: SAMPLE_W];
      end else begin
        s1_next[ch*SAMPLE_W +: SAMPLE_W] = gen_word;
      end
    end
  end

  // Ramp and alternation phase run on EN alone so pattern switches never restart them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_sync  <= 1'b0;
      ramp     <= '0;
      alt      <= 1'b0;
    end else begin
      s1_data  <= s1_next;
      s1_valid <= bus.en;
      s1_sync  <= bus.en && (ramp == '0);
      if (bus.en) begin
        ramp <= ramp + RAMP_STEP;
        alt  <= ~alt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= s1_sync;
      if (s1_valid) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Lane 2i carries channel i bits 5:0, lane 2i+1 bits 11:6, matching the flat sample packing.
  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    adcemu_lane_slip u_slip (
      .clk   (clk),
      .rst_n (rst_n),
      .cur   (s1_data[l*LANE_W +: LANE_W]),
      .slip  (bus.slip[l*SLIP_W +: SLIP_W]),
      .load  (bus.slip_ld),
      .word  (dout_w[l*LANE_W +: LANE_W])
    );
  end

  adcemu_lane_slip u_frame_slip (
    .clk   (clk),
    .rst_n (rst_n),
    .cur   (FRAME_PAT),
    .slip  (bus.slip[NLANE*SLIP_W +: SLIP_W]),
    .load  (bus.slip_ld),
    .word  (fr_w)
  );

  assign bus.dout    = dout_w;
  assign bus.fr      = fr_w;
  assign bus.sync    = sync_q;
  assign bus.smp_cnt = cnt_q;

endmodule

// File: tb/tb_adcemu_tx.sv
// tb/tb_adcemu_tx.sv - table vectors, directed corner sequences and randomized run against a stream model
module tb_adcemu_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adcemu_tx_if bus ();

  adcemu_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: sample content from the count of enabled cycles; slip as a delayed serial stream.
  int          m_en_cnt;
  logic [11:0] m_s1 [4];
  bit          m_s1_v, m_s1_sync;
  logic [5:0]  m_prev [9];
  int          m_k [9];
  logic [47:0] e_dout;
  logic [5:0]  e_fr;
  bit          e_sync;
  logic [31:0] e_cnt;

  typedef struct {
    logic [3:0]  pat;
    logic [11:0] uw;
    logic [47:0] din;
    logic [26:0] slip;
    logic [47:0] exp_dout;
    logic [5:0]  exp_fr;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en_cnt = 0;
    m_s1_v = 0;
    m_s1_sync = 0;
    for (int i = 0; i < 4; i++) m_s1[i] = '0;
    for (int l = 0; l < 9; l++) begin
      m_prev[l] = '0;
      m_k[l] = 0;
    end
    e_dout = '0;
    e_fr = '0;
    e_sync = 0;
    e_cnt = '0;
  endtask

  task automatic model_edge(input bit c_en, input logic [3:0] c_pat, input logic [11:0] c_uw,
                            input logic [47:0] c_din, input logic [26:0] c_slip, input bit c_ld);
    logic [5:0] cur;
    int rv, f;
    for (int l = 0; l < 9; l++) begin
      if (l == 8) cur = 6'b111000;
      else if (l % 2 == 1) cur = m_s1[l/2][11:6];
      else cur = m_s1[l/2][5:0];
      f = ((int'(m_prev[l]) * 64 + int'(cur)) >> m_k[l]) & 63;
      if (l == 8) e_fr = 6'(f);
      else e_dout[l*6 +: 6] = 6'(f);
      m_prev[l] = cur;
      if (c_ld) begin
        f = int'((c_slip >> (3 * l)) & 27'd7);
        m_k[l] = (f > 5) ? 5 : f;
      end
    end
    e_sync = m_s1_sync;
    if (m_s1_v) e_cnt = e_cnt + 1;
    m_s1_v = c_en;
    m_s1_sync = 0;
    for (int ch = 0; ch < 4; ch++) m_s1[ch] = '0;
    if (c_en) begin
      rv = m_en_cnt % 4096;
      m_s1_sync = (rv == 0);
      for (int ch = 0; ch < 4; ch++) begin
        case (c_pat)
          4'd0: m_s1[ch] = c_din[ch*12 +: 12];
          4'd2: m_s1[ch] = 12'hFFF;
          4'd3: m_s1[ch] = (m_en_cnt % 2 == 0) ? 12'hAAA : 12'h555;
          4'd4: m_s1[ch] = 12'(rv);
          4'd5: m_s1[ch] = c_uw;
          default: m_s1[ch] = 12'h000;
        endcase
      end
      m_en_cnt++;
    end
  endtask

  // Called at a negedge; inputs must already be set. Returns at the following negedge.
  task automatic tick();
    bit c_en, c_ld, c_rst;
    logic [3:0] c_pat;
    logic [11:0] c_uw;
    logic [47:0] c_din;
    logic [26:0] c_slip;
    c_en = bus.en; c_ld = bus.slip_ld; c_pat = bus.pat_type; c_uw = bus.user_word;
    c_din = bus.din; c_slip = bus.slip; c_rst = rst_n;
    @(posedge clk);
    if (!c_rst) model_reset();
    else model_edge(c_en, c_pat, c_uw, c_din, c_slip, c_ld);
    #1;
    tests++;
    if (bus.dout !== e_dout || bus.fr !== e_fr || bus.sync !== e_sync || bus.smp_cnt !== e_cnt) begin
      fails++;
      $display("FAIL model t=%0t actual dout=%h fr=%h sync=%b cnt=%0d required dout=%h fr=%h sync=%b cnt=%0d",
               $time, bus.dout, bus.fr, bus.sync, bus.smp_cnt, e_dout, e_fr, e_sync, e_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    int bad_sync;
    logic [5:0] last;
    logic [31:0] hold;

    vecs[0] = '{4'd2, 12'h000, 48'h0, 27'o0,         48'hFFFF_FFFF_FFFF, 6'b111000};
    vecs[1] = '{4'd1, 12'h000, 48'h0, 27'o200000000, 48'h0000_0000_0000, 6'b001110};
    vecs[2] = '{4'd5, 12'hABC, 48'h0, 27'o1,         48'hABCA_BCAB_CA9E, 6'b111000};
    vecs[3] = '{4'd5, 12'hABC, 48'h0, 27'o7000,      48'hABCA_BC57_CABC, 6'b111000};
    vecs[4] = '{4'd0, 12'h000, 48'h123_456_789_DEF, 27'o0, 48'h1234_5678_9DEF, 6'b111000};

    bus.en = 0; bus.pat_type = 4'd0; bus.user_word = '0; bus.din = '0;
    bus.slip = '0; bus.slip_ld = 0;
    model_reset();
    @(negedge clk);
    tick();
    chk("reset_dout", 64'(bus.dout), 64'h0);
    chk("reset_fr", 64'(bus.fr), 64'h0);
    chk("reset_cnt", 64'(bus.smp_cnt), 64'h0);
    rst_n = 1;
    tick();
    chk("first_fr", 64'(bus.fr), 64'h38);
    chk("idle_dout", 64'(bus.dout), 64'h0);

    // Ramp from reset: value 0 with SYNC, then 1, and SYNC again 4096 words later.
    bus.en = 1; bus.pat_type = 4'd4;
    tick();
    tick();
    chk("ramp0_val", 64'(bus.dout[11:0]), 64'd0);
    chk("ramp0_sync", 64'(bus.sync), 64'd1);
    tick();
    chk("ramp1_val", 64'(bus.dout[11:0]), 64'd1);
    chk("ramp1_ch3", 64'(bus.dout[47:36]), 64'd1);
    bad_sync = 0;
    for (int i = 0; i < 4094; i++) begin
      tick();
      if (bus.sync !== 1'b0) bad_sync++;
    end
    chk("ramp_no_early_sync", 64'(bad_sync), 64'd0);
    tick();
    chk("ramp_wrap_sync", 64'(bus.sync), 64'd1);
    chk("ramp_wrap_val", 64'(bus.dout[11:0]), 64'd0);

    // Alternating pattern, slips cleared first.
    bus.pat_type = 4'd3; bus.slip = '0; bus.slip_ld = 1;
    tick();
    bus.slip_ld = 0;
    for (int i = 0; i < 3; i++) tick();
    last = bus.dout[5:0];
    chk("alt_first", 64'((last == 6'h2A) || (last == 6'h15)), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alt_lane0", 64'(bus.dout[5:0]), (last == 6'h2A) ? 64'h15 : 64'h2A);
      chk("alt_ch2", 64'(bus.dout[35:24]), (last == 6'h2A) ? 64'h555 : 64'hAAA);
      last = bus.dout[5:0];
    end

    // Table-driven steady-state vectors.
    for (int v = 0; v < 5; v++) begin
      bus.pat_type = vecs[v].pat; bus.user_word = vecs[v].uw; bus.din = vecs[v].din;
      bus.slip = vecs[v].slip; bus.slip_ld = 1;
      tick();
      bus.slip_ld = 0;
      for (int i = 0; i < 4; i++) tick();
      chk($sformatf("vec%0d_dout", v), 64'(bus.dout), 64'(vecs[v].exp_dout));
      chk($sformatf("vec%0d_fr", v), 64'(bus.fr), 64'(vecs[v].exp_fr));
    end

    // EN low: in-flight word exits, then zeros with the counter held.
    bus.en = 0;
    tick();
    hold = e_cnt;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("en_low_dout", 64'(bus.dout), 64'h0);
      chk("en_low_fr", 64'(bus.fr), 64'h38);
      chk("en_low_cnt", 64'(bus.smp_cnt), 64'(hold));
    end

    // Reset pulse mid-ramp at value 100.
    rst_n = 0;
    tick();
    rst_n = 1; bus.slip = '0; bus.en = 1; bus.pat_type = 4'd4;
    for (int i = 0; i < 102; i++) tick();
    chk("mid_ramp_100", 64'(bus.dout[11:0]), 64'd100);
    rst_n = 0;
    #1;
    chk("async_rst_dout", 64'(bus.dout), 64'h0);
    chk("async_rst_fr", 64'(bus.fr), 64'h0);
    chk("async_rst_cnt", 64'(bus.smp_cnt), 64'h0);
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1;
    tick();
    chk("rerst_fr", 64'(bus.fr), 64'h38);
    tick();
    chk("rerst_ramp0", 64'(bus.dout[11:0]), 64'd0);
    chk("rerst_sync", 64'(bus.sync), 64'd1);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      bus.pat_type = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      bus.user_word = 12'($urandom);
      bus.din = {16'($urandom), $urandom};
      bus.slip = 27'($urandom);
      bus.slip_ld = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
